quad_input_filter: RTL and testbench

Conditioning stage directly upstream of the quadrature counter. It synchronises the raw encoder channels A_raw/B_raw into clk and rejects glitches with a per-channel stability filter. Its clean A/B outputs drive the counter's A/B inputs. It also decodes 4x quadrature steps into a direction-qualified step strobe and a wrapping 32-bit position, and it flags illegal double transitions.

---
 rtl/quad_input_filter.sv | 166 ++++++++++++++++
 tb/tb_quad_input_filter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_input_filter.sv
// quad_input_filter: front end for a quadrature encoder interface.
// It synchronises and glitch-filters the raw A/B channels. It decodes 4x
// quadrature steps into a step strobe, a direction and a wrapping 32-bit
// position, and it counts illegal double transitions with saturation.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int FILTER_LEN  = 8    // 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        A_raw,
  input  logic        B_raw,
  output logic        A,
  output logic        B,
  output logic        step,
  output logic        dir,
  output logic [31:0] pos,
  output logic        err,
  output logic [15:0] err_count
);

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [7:0] FILT_LAST  = 8'(FILTER_LEN - 1);
  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

  logic [0:0]             state_q, state_d;
  logic [2:0]             prime_cnt_q, prime_cnt_d;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [7:0]             filt_a_q, filt_a_d;
  logic [7:0]             filt_b_q, filt_b_d;
  logic                   a_q, a_d;
  logic                   b_q, b_d;
  logic [1:0]             prev_q, prev_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic [31:0]            pos_q, pos_d;
  logic                   err_q, err_d;
  logic [15:0]            err_count_q, err_count_d;

  logic                   s_a, s_b;
  logic [1:0]             phase_delta;

  assign s_a = sync_a_q[SYNC_STAGES-1];
  assign s_b = sync_b_q[SYNC_STAGES-1];

  // One channel of the stability filter: returns {next level, next counter}.
  function automatic logic [8:0] filter_step(input logic s, input logic x,
                                             input logic [7:0] cnt);
    if (s == x)               return {x, 8'd0};
    else if (cnt == FILT_LAST) return {~x, 8'd0};
    else                       return {x, cnt + 8'd1};
  endfunction

  // Position of an {A,B} pair along the forward cycle 00->10->11->01.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Next-state logic: synchroniser shift, prime/run sequencing, filter, decoder.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    sync_a_d    = {sync_a_q[SYNC_STAGES-2:0], A_raw};
    sync_b_d    = {sync_b_q[SYNC_STAGES-2:0], B_raw};
    filt_a_d    = filt_a_q;
    filt_b_d    = filt_b_q;
    a_d         = a_q;
    b_d         = b_q;
    prev_d      = prev_q;
    step_d      = 1'b0;
    dir_d       = dir_q;
    pos_d       = pos_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    phase_delta = quad_phase({a_q, b_q}) - quad_phase(prev_q);

    case (state_q)
      ST_PRIME: begin
        // Outputs track the synchroniser directly until it holds real samples.
        a_d      = s_a;
        b_d      = s_b;
        prev_d   = {s_a, s_b};
        filt_a_d = 8'd0;
        filt_b_d = 8'd0;
        if (prime_cnt_q == PRIME_LAST) state_d = ST_RUN;
        else                           prime_cnt_d = prime_cnt_q + 3'd1;
      end
      default: begin
        {a_d, filt_a_d} = filter_step(s_a, a_q, filt_a_q);
        {b_d, filt_b_d} = filter_step(s_b, b_q, filt_b_q);
        prev_d = {a_q, b_q};
        case (phase_delta)
          2'd1: begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_q + 32'd1;
          end
          2'd3: begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_q - 32'd1;
          end
          2'd2: begin
            err_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end
          default: ;
        endcase
      end
    endcase
  end

  // State registers with synchronous reset that overrides every other update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= ST_PRIME;
      prime_cnt_q <= 3'd0;
      sync_a_q    <= '0;
      sync_b_q    <= '0;
      filt_a_q    <= 8'd0;
      filt_b_q    <= 8'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      prev_q      <= 2'b00;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      pos_q       <= 32'd0;
      err_q       <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      sync_a_q    <= sync_a_d;
      sync_b_q    <= sync_b_d;
      filt_a_q    <= filt_a_d;
      filt_b_q    <= filt_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prev_q      <= prev_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign step      = step_q;
  assign dir       = dir_q;
  assign pos       = pos_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_quad_input_filter.sv
// Bench for quad_input_filter: scoreboarded step/err events on a default
// instance, plus a FILTER_LEN=1 instance that saturates err_count quickly.
module tb_quad_input_filter;

  localparam int S   = 2;
  localparam int F   = 8;
  localparam int LAT = S + F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic        reset, a_raw, b_raw;
  logic        a, b, step, dir, err;
  logic [31:0] pos;
  logic [15:0] err_count;

  // Fast-filter instance used for saturation.
  logic        reset1, a1_raw, b1_raw;
  logic        a1, b1, step1, dir1, err1;
  logic [31:0] pos1;
  logic [15:0] ec1;

  quad_input_filter #(.SYNC_STAGES(S), .FILTER_LEN(F)) u_dut (
    .clk(clk), .reset(reset), .A_raw(a_raw), .B_raw(b_raw),
    .A(a), .B(b), .step(step), .dir(dir), .pos(pos), .err(err),
    .err_count(err_count)
  );

  quad_input_filter #(.SYNC_STAGES(2), .FILTER_LEN(1)) u_sat (
    .clk(clk), .reset(reset1), .A_raw(a1_raw), .B_raw(b1_raw),
    .A(a1), .B(b1), .step(step1), .dir(dir1), .pos(pos1), .err(err1),
    .err_count(ec1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected event: {err, dir, pos, err_count}.
  logic [49:0] exp_q[$];
  logic [49:0] exp_e;

  // Reference model of the decoded state.
  logic [1:0]  m_ab;
  logic        m_dir;
  logic [31:0] m_pos;
  logic [15:0] m_ec;

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Drive a raw pair for 'hold' clock edges; predict the event if it gets through.
  task automatic apply(input logic [1:0] ab, input int hold);
    logic [1:0] old;
    logic       accepted;
    old      = m_ab;
    accepted = (ab != m_ab) && (hold >= F);
    if (accepted) begin
      if (ab == fwd_next(old)) begin
        m_dir = 1'b1;
        m_pos = m_pos + 32'd1;
        exp_q.push_back({1'b0, m_dir, m_pos, m_ec});
      end else if (old == fwd_next(ab)) begin
        m_dir = 1'b0;
        m_pos = m_pos - 32'd1;
        exp_q.push_back({1'b0, m_dir, m_pos, m_ec});
      end else begin
        if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
        exp_q.push_back({1'b1, m_dir, m_pos, m_ec});
      end
      m_ab = ab;
    end
    @(negedge clk);
    a_raw = ab[1];
    b_raw = ab[0];
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (accepted && i == LAT - 1) check("lat_before", {a, b}, old);
      if (accepted && i == LAT)     check("lat_after",  {a, b}, ab);
    end
  endtask

  // Reset the default instance with a raw pair held, then walk through PRIME.
  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    reset = 1'b1;
    a_raw = ab[1];
    b_raw = ab[0];
    @(posedge clk);
    #1;
    check("reset_clear", {a, b, step, dir, pos, err, err_count}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_ab  = ab;
    m_dir = 1'b0;
    m_pos = 32'd0;
    m_ec  = 16'd0;
    for (int i = 1; i <= S + 1; i++) begin
      @(posedge clk);
      #1;
      check("prime_quiet", {step, err, pos}, '0);
      if (i == S)     check("prime_ab_early", {a, b}, 2'b00);
      if (i == S + 1) check("prime_ab", {a, b}, ab);
    end
  endtask

  // Scoreboard: every step/err pulse must match the next predicted event.
  always @(negedge clk) begin
    if (step || err) begin
      check("step_err_excl", step & err, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {step, err}, 2'b00);
      end else begin
        exp_e = exp_q.pop_front();
        check("evt", {err, dir, pos, err_count}, exp_e);
      end
    end
  end

  // Saturation monitor: err_count must equal the saturated number of err pulses.
  logic mon1 = 1'b0;
  int   sat_pulses = 0;
  always @(negedge clk) begin
    if (mon1) begin
      if (step1) check("sat_no_step", step1, 1'b0);
      if (err1) begin
        sat_pulses++;
        if (sat_pulses == 1000 || sat_pulses == 65535 ||
            sat_pulses == 65536 || sat_pulses == 65590)
          check("sat_count", ec1, (sat_pulses > 65535) ? 65535 : sat_pulses);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    a_raw  = 1'b1;
    b_raw  = 1'b1;
    reset1 = 1'b1;
    a1_raw = 1'b0;
    b1_raw = 1'b0;
    m_ab   = 2'b11;
    m_dir  = 1'b0;
    m_pos  = 32'd0;
    m_ec   = 16'd0;

    // Reset release with 11 held.
    do_reset(2'b11);
    apply(2'b11, 5);

    // Forward then reverse cycles from 00.
    do_reset(2'b00);
    apply(2'b00, 5);
    apply(2'b10, 20);
    apply(2'b11, 20);
    apply(2'b01, 20);
    apply(2'b00, 20);
    check("fwd_pos", pos, 32'd4);
    check("fwd_dir", dir, 1'b1);
    check("fwd_ec", err_count, 16'd0);
    apply(2'b01, 20);
    apply(2'b11, 20);
    apply(2'b10, 20);
    apply(2'b00, 20);
    check("rev_pos", pos, 32'd0);
    check("rev_dir", dir, 1'b0);

    // Position wraps below zero and back.
    apply(2'b01, 20);
    check("wrap_neg", pos, 32'hFFFF_FFFF);
    apply(2'b00, 20);
    check("wrap_back", pos, 32'd0);

    // Glitch rejection: 7-cycle pulse vanishes, 8-cycle pulse passes.
    apply(2'b10, 7);
    apply(2'b00, 20);
    check("pulse7_a", a, 1'b0);
    apply(2'b10, 8);
    apply(2'b00, 20);
    check("pulse8_pos", pos, 32'd0);

    // Illegal double transition, then a step judged from the new pair.
    apply(2'b11, 20);
    check("illegal_ec", err_count, 16'd1);
    check("illegal_pos", pos, 32'd0);
    apply(2'b01, 20);
    check("after_illegal_pos", pos, 32'd1);
    check("after_illegal_dir", dir, 1'b1);

    // Reset in the middle of a filter count.
    apply(2'b10, 5);
    do_reset(2'b01);
    apply(2'b01, 20);
    check("sb_empty", exp_q.size(), 0);

    // Saturate err_count on the fast-filter instance.
    @(negedge clk);
    reset1 = 1'b0;
    repeat (5) @(posedge clk);
    mon1 = 1'b1;
    for (int i = 0; i < 65600; i++) begin
      @(negedge clk);
      a1_raw = ~a1_raw;
      b1_raw = ~b1_raw;
    end
    @(posedge clk);
    #1;
    check("sat_final", ec1, 16'hFFFF);
    check("sat_err_pulsing", err1, 1'b1);
    check("sat_pulses_ge", sat_pulses >= 65590, 1'b1);
    check("sat_pos", pos1, 32'd0);

    // Mid-sequence reset clears everything, including a saturated counter.
    @(negedge clk);
    reset1 = 1'b1;
    @(posedge clk);
    #1;
    check("sat_reset_clear", {a1, b1, step1, dir1, pos1, err1, ec1}, '0);
    @(negedge clk);
    reset1 = 1'b0;
    a1_raw = 1'b0;
    b1_raw = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check("sat_prime_quiet", {step1, err1, ec1}, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
